elevator_sequencer: RTL and testbench
=====================================

// Module: elevator_sequencer
// PURPOSE
//  Car controller that sequences the shared 4-bit seconds timer (restart/done/seconds interface) to run one elevator car.
//  Latches floor calls, picks a travel direction (SCAN: keep direction while calls lie ahead) and times each phase.
//  Each floor-to-floor move lasts TRAVEL_SEC; each door-open dwell lasts DOOR_SEC.
//  Sits between the call-button logic and the motor/door/display drivers; it is the only master of the timer.
// PARAMETERS
//  N_FLOORS    4  number of floors, floor 0 is ground (2..16)
//  FLOOR_W     2  width of floor index, >= clog2(N_FLOORS)
//  TRAVEL_SEC  2  timer seconds per single-floor move (1..15)
//  DOOR_SEC    3  timer seconds door stays open (1..15)
// PORTS
//  clk         in   1         system clock, rising edge
//  reseta      in   1         asynchronous, active-low reset
//  floor_req   in   N_FLOORS  call buttons, one bit per floor, level or pulse
//  tmr_done    in   1         timer acknowledges restart (timer held cleared)
//  tmr_sec     in   4         timer seconds since last restart
//  tmr_clr     out  1         timer restart request, held until tmr_done=1
//  cur_floor   out  FLOOR_W   floor the car is at / last passed
//  motor_up    out  1         car moving up (MOVE state, dir=up)
//  motor_down  out  1         car moving down (MOVE state, dir=down)
//  door_open   out  1         door open (OPEN state)
//  pending     out  N_FLOORS  latched, unserved calls
//  busy        out  1         state != IDLE
// BEHAVIOUR
//  Reset (reseta=0, async): state=IDLE, cur_floor=0, dir=up, pending=0, all outputs 0. Asserting it mid-move or mid-dwell
//    aborts the phase; the car is defined to be back at floor 0.
//  Call latch: each cycle pending |= floor_req, except the cur_floor bit, which is ignored while in OPEN or when entering it.
//  States: IDLE, CLR, MOVE, OPEN. Register nxt in {MOVE,OPEN} records the phase that follows CLR.
//  IDLE decision (one cycle), in priority order:
//    1. pending[cur_floor]=1: nxt=OPEN, go to CLR.
//    2. a call exists strictly ahead in dir: nxt=MOVE, go to CLR.
//    3. a call exists strictly behind: flip dir, nxt=MOVE, go to CLR.
//    4. otherwise stay in IDLE, dir unchanged.
//  CLR: tmr_clr=1. On the first cycle with tmr_done=1 go to nxt; tmr_clr falls in that same transition.
//    CLR never times out.
//  MOVE: motor_up/motor_down = dir. When tmr_sec == TRAVEL_SEC:
//    - cur_floor steps by ±1, go to IDLE.
//    - motors drop the same edge cur_floor updates.
//  OPEN: clears pending[cur_floor] on entry; door_open=1. When tmr_sec == DOOR_SEC: door_open=0, go to IDLE.
//  Comparisons use equality on the 4-bit tmr_sec, which starts from 0 after CLR, so the wrap at 15 is never reached.
//  cur_floor never leaves 0..N_FLOORS-1: a MOVE is started only when a call lies in that direction.
//  At floor 0 or the top floor with no calls ahead, rule 3 reverses direction.
//  Simultaneous calls at several floors: served in SCAN order. A call that appears behind the car waits for reversal.
//  A call for the floor being passed during MOVE is latched and served when the car arrives there via IDLE rule 1.
//  Latency: call latched to tmr_clr high is 2 cycles (latch, then IDLE decision). Door opens 1 cycle after tmr_done.
// TESTING
//  Bench timer model: tmr_done=1 one cycle after tmr_clr rises; tmr_sec increments every 4 clk after tmr_clr falls.
//  1. Reset, floor_req=4'b0001 pulse at floor 0
//     -> CLR, door_open=1 for 3 s (12 clk), pending returns to 0, back in IDLE with cur_floor=0.
//  2. Reset, floor_req=4'b1000
//     -> motor_up high for 3 moves of 8 clk each, cur_floor 1,2,3, then door_open=1, pending=0, dir stays up.
//  3. Car at floor 3 idle, floor_req=4'b0001
//     -> dir flips to down, cur_floor 2,1,0 with motor_down=1, door opens at floor 0.
//  4. Car at 0 moving up to 3, floor_req=4'b0100 during the first move
//     -> door opens at floor 2 (stop), then continues to 3. pending never contains bit 0.
//  5. Hold tmr_done=0 for 50 clk in CLR
//     -> tmr_clr stays 1, no motor or door output; sequencing resumes once tmr_done=1.
//  6. Assert reseta=0 mid-MOVE between floors 1 and 2
//     -> all outputs 0 immediately, cur_floor=0, pending=0, IDLE after release.

Source files
------------

// File: rtl/elevator_sequencer.sv
// Single-car elevator controller: latches floor calls, picks a SCAN direction and
// times each move / door dwell with the shared seconds timer.
module elevator_sequencer #(
    parameter int unsigned N_FLOORS   = 4,
    parameter int unsigned FLOOR_W    = 2,
    parameter int unsigned TRAVEL_SEC = 2,
    parameter int unsigned DOOR_SEC   = 3
) (
    input  logic                clk,
    input  logic                reseta,
    input  logic [N_FLOORS-1:0] floor_req,
    input  logic                tmr_done,
    input  logic [3:0]          tmr_sec,
    output logic                tmr_clr,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic                motor_up,
    output logic                motor_down,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic                busy
);

    typedef enum logic [1:0] {StIdle, StClr, StMove, StOpen} state_e;

    state_e               state_q, state_d;
    logic                 nxt_open_q, nxt_open_d;
    logic                 dir_up_q, dir_up_d;
    logic [FLOOR_W-1:0]   cur_floor_q, cur_floor_d;
    logic [N_FLOORS-1:0]  pending_q, pending_d;
    logic                 calls_above, calls_below;
    logic                 calls_ahead, calls_behind;

    always_comb begin
        calls_above = 1'b0;
        calls_below = 1'b0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (pending_q[i] && (i > int'(cur_floor_q))) calls_above = 1'b1;
            if (pending_q[i] && (i < int'(cur_floor_q))) calls_below = 1'b1;
        end
    end

    assign calls_ahead  = dir_up_q ? calls_above : calls_below;
    assign calls_behind = dir_up_q ? calls_below : calls_above;

    always_comb begin
        state_d     = state_q;
        nxt_open_d  = nxt_open_q;
        dir_up_d    = dir_up_q;
        cur_floor_d = cur_floor_q;
        unique case (state_q)
            StIdle: begin
                if (pending_q[cur_floor_q]) begin
                    nxt_open_d = 1'b1;
                    state_d    = StClr;
                end else if (calls_ahead) begin
                    nxt_open_d = 1'b0;
                    state_d    = StClr;
                end else if (calls_behind) begin
                    dir_up_d   = ~dir_up_q;
                    nxt_open_d = 1'b0;
                    state_d    = StClr;
                end
            end
            StClr: begin
                if (tmr_done) state_d = nxt_open_q ? StOpen : StMove;
            end
            StMove: begin
                if (tmr_sec == 4'(TRAVEL_SEC)) begin
                    cur_floor_d = dir_up_q ? cur_floor_q + FLOOR_W'(1)
                                           : cur_floor_q - FLOOR_W'(1);
                    state_d     = StIdle;
                end
            end
            StOpen: begin
                if (tmr_sec == 4'(DOOR_SEC)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A call for the floor whose door is (or is about to be) open is already served.
        pending_d = pending_q | floor_req;
        if ((state_q == StOpen) || (state_d == StOpen)) pending_d[cur_floor_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            state_q     <= StIdle;
            nxt_open_q  <= 1'b0;
            dir_up_q    <= 1'b1;
            cur_floor_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            nxt_open_q  <= nxt_open_d;
            dir_up_q    <= dir_up_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
        end
    end

    assign tmr_clr    = (state_q == StClr);
    assign motor_up   = (state_q == StMove) && dir_up_q;
    assign motor_down = (state_q == StMove) && !dir_up_q;
    assign door_open  = (state_q == StOpen);
    assign busy       = (state_q != StIdle);
    assign cur_floor  = cur_floor_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_elevator_sequencer.sv
// Bench for elevator_sequencer: timer model, per-cycle behavioural reference,
// directed scenarios with literal expectations and a randomized call phase.
module tb_elevator_sequencer;

    localparam int NF = 4;
    localparam int TS = 2;
    localparam int DS = 3;

    logic       clk = 1'b0;
    logic       reseta = 1'b0;
    logic [3:0] floor_req = 4'b0;
    logic       tmr_done = 1'b0;
    logic [3:0] tmr_sec = 4'b0;
    logic       tmr_clr;
    logic [1:0] cur_floor;
    logic       motor_up, motor_down, door_open, busy;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    bit stall = 1'b0;
    int tdiv = 0;

    elevator_sequencer #(
        .N_FLOORS  (NF),
        .FLOOR_W   (2),
        .TRAVEL_SEC(TS),
        .DOOR_SEC  (DS)
    ) dut (
        .clk       (clk),
        .reseta    (reseta),
        .floor_req (floor_req),
        .tmr_done  (tmr_done),
        .tmr_sec   (tmr_sec),
        .tmr_clr   (tmr_clr),
        .cur_floor (cur_floor),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .door_open (door_open),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Seconds timer: acknowledges a restart one cycle later, then counts a second every 4 clk.
    always @(negedge clk) begin
        if (tmr_clr) begin
            tmr_done = !stall;
            tmr_sec  = 4'd0;
            tdiv     = 0;
        end else begin
            tmr_done = 1'b0;
            tdiv++;
            if (tdiv == 4) begin
                tdiv    = 0;
                tmr_sec = tmr_sec + 4'd1;
            end
        end
    end

    // Reference car: phase names, floor number as an integer, call set as a bit vector.
    typedef enum {MIdle, MClr, MMove, MOpen} mphase_t;
    mphase_t  m_ph, m_after, m_old;
    int       m_floor;
    bit       m_up;
    bit [3:0] m_pend;

    function automatic bit any_call(input bit [3:0] p, input int f, input bit up);
        for (int i = 0; i < NF; i++)
            if (p[i] && (up ? (i > f) : (i < f))) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reseta) begin
        if (!reseta) begin
            m_ph = MIdle; m_after = MMove; m_floor = 0; m_up = 1'b1; m_pend = 4'b0;
        end else begin
            m_old = m_ph;
            case (m_ph)
                MIdle: begin
                    if (m_pend[m_floor]) begin
                        m_after = MOpen; m_ph = MClr;
                    end else if (any_call(m_pend, m_floor, m_up)) begin
                        m_after = MMove; m_ph = MClr;
                    end else if (any_call(m_pend, m_floor, !m_up)) begin
                        m_up = !m_up; m_after = MMove; m_ph = MClr;
                    end
                end
                MClr:  if (tmr_done) m_ph = m_after;
                MMove: if (int'(tmr_sec) == TS) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    m_ph = MIdle;
                end
                MOpen: if (int'(tmr_sec) == DS) m_ph = MIdle;
                default: m_ph = MIdle;
            endcase
            m_pend = m_pend | floor_req;
            if (m_old == MOpen || m_ph == MOpen) m_pend[m_floor] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_tmr_clr", int'(tmr_clr), int'(m_ph == MClr));
            check("cyc_motor_up", int'(motor_up), int'(m_ph == MMove && m_up));
            check("cyc_motor_down", int'(motor_down), int'(m_ph == MMove && !m_up));
            check("cyc_door_open", int'(door_open), int'(m_ph == MOpen));
            check("cyc_busy", int'(busy), int'(m_ph != MIdle));
            check("cyc_cur_floor", int'(cur_floor), m_floor);
            check("cyc_pending", int'(pending), int'(m_pend));
        end
    end

    function automatic int sig(input int sel);
        case (sel)
            0: return int'(tmr_clr);
            1: return int'(door_open);
            2: return int'(busy);
            3: return int'(motor_up);
            4: return int'(motor_down);
            5: return int'(!busy && pending == 4'b0);
            default: return 0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int val, input int budget, input string name);
        int n = 0;
        while (sig(sel) != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) != val) check(name, sig(sel), val);
    endtask

    task automatic pulse(input logic [3:0] req);
        floor_req = req;
        @(negedge clk);
        floor_req = 4'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, cyc, ok;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check("rst_busy", int'(busy), 0);
        check("rst_floor", int'(cur_floor), 0);
        check("rst_outputs", int'({tmr_clr, motor_up, motor_down, door_open}), 0);
        @(negedge clk);
        reseta = 1'b1;

        // 1: call at the current floor -> door dwell of 3 s
        floor_req = 4'b0001;
        @(negedge clk);
        floor_req = 4'b0;
        lat = 1;
        while (!tmr_clr && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t1_clr_latency", lat, 2);
        wait_sig(1, 1, 20, "t1_door_wait");
        n = 0;
        while (door_open && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t1_door_cycles", n, 12);
        wait_sig(5, 1, 20, "t1_idle_wait");
        check("t1_floor", int'(cur_floor), 0);

        // 2: call at the top floor -> three moves up
        pulse(4'b1000);
        n = 0; cyc = 0;
        while (!door_open && cyc < 300) begin
            if (motor_up) n++;
            @(negedge clk);
            cyc++;
        end
        check("t2_motor_up_cycles", n, 24);
        check("t2_floor", int'(cur_floor), 3);
        wait_sig(5, 1, 50, "t2_idle_wait");
        check("t2_pending", int'(pending), 0);

        // 3: reversal from the top floor down to ground
        pulse(4'b0001);
        n = 0; cyc = 0;
        while (!door_open && cyc < 300) begin
            if (motor_down) n++;
            @(negedge clk);
            cyc++;
        end
        check("t3_motor_down_cycles", n, 24);
        check("t3_floor", int'(cur_floor), 0);
        wait_sig(5, 1, 50, "t3_idle_wait");

        // 4: call ahead appears during the first move -> intermediate stop
        pulse(4'b1000);
        wait_sig(3, 1, 20, "t4_move_wait");
        repeat (2) @(negedge clk);
        pulse(4'b0100);
        wait_sig(1, 1, 300, "t4_door1_wait");
        check("t4_stop_floor", int'(cur_floor), 2);
        wait_sig(1, 0, 50, "t4_door1_close");
        wait_sig(1, 1, 300, "t4_door2_wait");
        check("t4_final_floor", int'(cur_floor), 3);
        wait_sig(5, 1, 50, "t4_idle_wait");

        // 5: timer withholds tmr_done for 50 clk
        stall = 1'b1;
        pulse(4'b0010);
        wait_sig(0, 1, 10, "t5_clr_wait");
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (tmr_clr && !motor_up && !motor_down && !door_open) ok++;
            @(negedge clk);
        end
        check("t5_clr_held", ok, 50);
        stall = 1'b0;
        wait_sig(1, 1, 300, "t5_door_wait");
        check("t5_floor", int'(cur_floor), 1);
        wait_sig(5, 1, 50, "t5_idle_wait");

        // 6: asynchronous reset between floors 1 and 2
        pulse(4'b1000);
        wait_sig(3, 1, 20, "t6_move_wait");
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reseta = 1'b0;
        #1;
        check("t6_motor_up", int'(motor_up), 0);
        check("t6_floor", int'(cur_floor), 0);
        check("t6_pending", int'(pending), 0);
        check("t6_busy", int'(busy), 0);
        @(negedge clk);
        reseta = 1'b1;
        @(negedge clk);
        check("t6_idle_after", int'(busy), 0);

        // Randomized calls and timer stalls against the reference
        for (int c = 0; c < 3000; c++) begin
            floor_req = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            stall = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        floor_req = 4'b0;
        stall = 1'b0;
        wait_sig(5, 1, 3000, "rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
